// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  // Arbiter phases: hand out a grant, hold it, then open a gap before the next owner.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle of the shared mux path: requests and data in, grants and muxed beat out.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic [3:0]       gnt;
  logic             sel_s0;
  logic             sel_s1;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  // Requesters drive requests and data and observe the arbiter results.
  modport master (
    output req, in_data0, in_data1, in_data2, in_data3,
    input  gnt, sel_s0, sel_s1, out_valid, out_data, busy
  );

  // The arbiter consumes requests and data and drives the results.
  modport slave (
    input  req, in_data0, in_data1, in_data2, in_data3,
    output gnt, sel_s0, sel_s1, out_valid, out_data, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter_mux_cell.sv
// 1-bit gate-level 4:1 mux cell; s1 selects the upper pair, s0 the member of the pair.
module mux4_rr_arbiter_mux_cell (
  input  wire i_d0,
  input  wire i_d1,
  input  wire i_d2,
  input  wire i_d3,
  input  wire i_s0,
  input  wire i_s1,
  output wire o_y
);

  wire w_ns0;
  wire w_ns1;
  wire w_t0;
  wire w_t1;
  wire w_t2;
  wire w_t3;

  not g_ns0 (w_ns0, i_s0);
  not g_ns1 (w_ns1, i_s1);
  and g_t0  (w_t0, i_d0, w_ns1, w_ns0);
  and g_t1  (w_t1, i_d1, w_ns1, i_s0);
  and g_t2  (w_t2, i_d2, i_s1,  w_ns0);
  and g_t3  (w_t3, i_d3, i_s1,  i_s0);
  or  g_y   (o_y, w_t0, w_t1, w_t2, w_t3);

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping 3->0.
module mux4_rr_arbiter_rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_found,
  output logic [1:0] o_idx
);

  logic [1:0] w_cand;

  // Scan from the farthest offset down to ptr itself so the nearest request wins last.
  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared WIDTH-bit 4:1 mux path; registers grants, selects and the muxed beat.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  // Last cycle an owner may keep the path while someone else waits, and the counter ceiling.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);

  state_e               r_state;
  logic [1:0]           r_owner;
  logic [1:0]           r_ptr;
  logic [HOLD_W-1:0]    r_hold;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_sel_s0;
  logic                 r_sel_s1;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;

  logic                 w_found;
  logic [1:0]           w_idx;
  logic                 w_owner_req;
  logic                 w_others;
  logic                 w_beat;
  logic [WIDTH-1:0]     w_mux;

  mux4_rr_arbiter_rr_pick4 u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_owner_req = bus.req[r_owner];
  assign w_others    = |(bus.req & ~onehot4(r_owner));
  assign w_beat      = (r_state == ST_OWN) && w_owner_req;

  // Shared datapath: one gate-level mux cell per data bit, steered by the registered selects.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux4_rr_arbiter_mux_cell u_cell (
        .i_d0 (bus.in_data0[gi]),
        .i_d1 (bus.in_data1[gi]),
        .i_d2 (bus.in_data2[gi]),
        .i_d3 (bus.in_data3[gi]),
        .i_s0 (r_sel_s0),
        .i_s1 (r_sel_s1),
        .o_y  (w_mux[gi])
      );
    end
  endgenerate

  // Ownership FSM: grant on IDLE->OWN, hold until the owner drops or the hold limit forces a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_gnt    <= '0;
      r_sel_s0 <= 1'b0;
      r_sel_s1 <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner  <= w_idx;
            r_gnt    <= onehot4(w_idx);
            r_sel_s0 <= w_idx[0];
            r_sel_s1 <= w_idx[1];
            r_hold   <= '0;
            r_state  <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
          // A saturated counter still counts as past the limit, so a late contender cannot starve.
          if (!w_owner_req || ((r_hold >= HOLD_LAST) && w_others)) begin
            r_gnt   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_ptr   <= r_owner + 2'd1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output beat register: capture the owner's data whenever it presents a beat, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_beat;
      if (w_beat) begin
        r_data <= w_mux;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel_s0    = r_sel_s0;
  assign bus.sel_s1    = r_sel_s1;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a grant/gap behavioural model compared every cycle.
module tb_mux4_rr_arbiter;

  localparam int WIDTH    = 32;
  localparam int MAX_HOLD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [3:0]       req_d = '0;
  logic [WIDTH-1:0] din [4];

  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  assign bus.req      = req_d;
  assign bus.in_data0 = din[0];
  assign bus.in_data1 = din[1];
  assign bus.in_data2 = din[2];
  assign bus.in_data3 = din[3];

  mux4_rr_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a grant lasts while the owner requests, capped at MAX_HOLD cycles under contention,
  // followed by a fixed 2-cycle gap; the next owner is the nearest requester after the last one.
  bit         m_on;
  int         m_owner;
  int         m_hold;
  int         m_gap;
  int         m_ptr;
  logic       m_sel_s0;
  logic       m_sel_s1;
  logic       m_valid;
  logic [31:0] m_data;

  initial begin
    bit others;
    bit found;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_on = 0; m_owner = 0; m_hold = 0; m_gap = 0; m_ptr = 0;
        m_sel_s0 = 1'b0; m_sel_s1 = 1'b0; m_valid = 1'b0; m_data = '0;
      end else if (m_on) begin
        m_valid = req_d[m_owner];
        if (req_d[m_owner]) m_data = din[m_owner];
        m_hold++;
        others = 0;
        for (int k = 0; k < 4; k++) if (k != m_owner && req_d[k]) others = 1;
        if (!req_d[m_owner] || (m_hold >= MAX_HOLD && others)) begin
          m_on  = 0;
          m_gap = 1;
          m_ptr = (m_owner + 1) % 4;
        end
      end else if (m_gap > 0) begin
        m_gap--;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req_d[(m_ptr + k) % 4]) begin
            found    = 1;
            m_owner  = (m_ptr + k) % 4;
            m_on     = 1;
            m_hold   = 0;
            m_sel_s0 = (m_owner % 2) == 1;
            m_sel_s1 = m_owner >= 2;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  initial begin
    logic [3:0] exp_gnt;
    forever begin
      @(negedge clk);
      exp_gnt = m_on ? 4'(1 << m_owner) : 4'b0000;
      check("cyc_gnt",       64'(bus.gnt),       64'(exp_gnt));
      check("cyc_sel_s0",    64'(bus.sel_s0),    64'(m_sel_s0));
      check("cyc_sel_s1",    64'(bus.sel_s1),    64'(m_sel_s1));
      check("cyc_out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("cyc_out_data",  64'(bus.out_data),  64'(m_data));
      check("cyc_busy",      64'(bus.busy),      64'(m_on || m_gap > 0));
      check("cyc_onehot0",   64'($onehot0(bus.gnt)), 64'(1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_d = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic int gnt_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order [5];
    int exp_order [5];
    int ngr, zeros, cnt, cur;
    logic [3:0] prev, g;
    logic [3:0] seq [12];
    int nv, ng;

    exp_order = '{0, 1, 2, 3, 0};
    din[0] = 32'hA0A0_0000; din[1] = 32'hB1B1_0001;
    din[2] = 32'hC2C2_0002; din[3] = 32'hD3D3_0003;

    // 1: reset holds everything at zero, then idle with no requests
    rst_n = 1'b0;
    step();
    step();
    check("t1_rst_gnt",   64'(bus.gnt),       64'(0));
    check("t1_rst_s0",    64'(bus.sel_s0),    64'(0));
    check("t1_rst_s1",    64'(bus.sel_s1),    64'(0));
    check("t1_rst_valid", 64'(bus.out_valid), 64'(0));
    check("t1_rst_data",  64'(bus.out_data),  64'(0));
    check("t1_rst_busy",  64'(bus.busy),      64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_idle_gnt",  64'(bus.gnt),  64'(0));
      check("t1_idle_busy", 64'(bus.busy), 64'(0));
    end
    $display("test1 reset/idle done");

    // 2: single request from requester 2
    din[2] = 32'hCAFE_0002;
    req_d  = 4'b0100;
    step();
    check("t2_gnt",   64'(bus.gnt),       64'(4'b0100));
    check("t2_s1",    64'(bus.sel_s1),    64'(1));
    check("t2_s0",    64'(bus.sel_s0),    64'(0));
    check("t2_nobeat", 64'(bus.out_valid), 64'(0));
    step();
    check("t2_valid", 64'(bus.out_valid), 64'(1));
    check("t2_data",  64'(bus.out_data),  64'(32'hCAFE_0002));
    req_d = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    $display("test2 single request done");

    // 3: all four requesting, each owner drops after 2 beats and re-requests
    do_reset();
    req_d = 4'b1111;
    ngr = 0; zeros = 0; cnt = 0; prev = '0;
    for (int i = 0; i < 60 && ngr < 5; i++) begin
      step();
      g = bus.gnt;
      if (g != 0) begin
        cur = gnt_idx(g);
        if (prev == 0) begin
          if (ngr > 0) check("t3_gap", 64'(zeros), 64'(2));
          order[ngr] = cur;
          $display("test3 grant %0d to requester %0d", ngr, cur);
          ngr++;
          zeros = 0;
          cnt = 0;
        end
        cnt++;
        if (cnt == 3 && cur >= 0) req_d[cur] = 1'b0;
      end else begin
        if (prev != 0) req_d = 4'b1111;
        zeros++;
      end
      prev = g;
    end
    check("t3_grants_seen", 64'(ngr), 64'(5));
    for (int i = 0; i < 5; i++) if (i < ngr) check("t3_order", 64'(order[i]), 64'(exp_order[i]));
    req_d = 4'b0000;
    for (int i = 0; i < 6; i++) step();

    // 4: forced release after MAX_HOLD cycles when requester 3 waits
    do_reset();
    req_d = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      step();
      seq[i] = bus.gnt;
      if (i == 1) req_d[3] = 1'b1;
    end
    cnt = 0;
    while (cnt < 12 && seq[cnt] == 4'b0001) cnt++;
    check("t4_hold_len", 64'(cnt), 64'(8));
    check("t4_gap0",     64'(seq[8]),  64'(4'b0000));
    check("t4_gap1",     64'(seq[9]),  64'(4'b0000));
    check("t4_next",     64'(seq[10]), 64'(4'b1000));
    $display("test4 forced release after %0d cycles", cnt);
    req_d = 4'b0000;
    for (int i = 0; i < 6; i++) step();

    // 5: requester 1 alone for 20 beats, data changing every cycle
    do_reset();
    req_d = 4'b0010;
    nv = 0; ng = 0;
    for (int i = 0; i < 21; i++) begin
      din[1] = 32'h5000_0000 + 32'(i);
      step();
      if (bus.out_valid) nv++;
      if (bus.gnt == 4'b0010) ng++;
    end
    req_d = 4'b0000;
    check("t5_beats", 64'(nv), 64'(20));
    check("t5_gnt",   64'(ng), 64'(21));
    $display("test5 uncontended run beats=%0d", nv);
    for (int i = 0; i < 4; i++) step();

    // 6: asynchronous reset pulse between edges while owning
    do_reset();
    req_d = 4'b0100;
    step();
    step();
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt",   64'(bus.gnt),       64'(0));
    check("t6_async_valid", 64'(bus.out_valid), 64'(0));
    check("t6_async_busy",  64'(bus.busy),      64'(0));
    #1;
    rst_n = 1'b1;
    req_d = 4'b1010;
    step();
    check("t6_after_gnt", 64'(bus.gnt), 64'(4'b0010));
    req_d = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    $display("test6 async reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
